// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM encoding, NOP word and
// the rule that marks an instruction as carrying a trailing immediate word.
package fetch_pkg;

    localparam logic [15:0] NOP          = 16'h0000;
    localparam int          IMM_FLAG_BIT = 15;

    typedef enum logic [1:0] {
        RST_LO = 2'd0,
        RST_HI = 2'd1,
        RUN    = 2'd2,
        IMM    = 2'd3
    } fetch_state_t;

    function automatic logic is_two_word(input logic [15:0] word);
        return word[IMM_FLAG_BIT];
    endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register: bubble insertion beats a load, and with neither asserted
// every field holds. Bubble clears immediate and return address as well as valid.
module fd_pipe_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [IW-1:0]   instr_i,
    input  logic [IW-1:0]   imm_i,
    input  logic [PC_W-1:0] pc_next_i,
    output logic            valid_o,
    output logic [IW-1:0]   instr_o,
    output logic [IW-1:0]   imm_o,
    output logic [PC_W-1:0] pc_next_o
);

    logic            valid_q;
    logic [IW-1:0]   instr_q;
    logic [IW-1:0]   imm_q;
    logic [PC_W-1:0] pc_next_q;

    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            valid_q   <= 1'b0;
            instr_q   <= IW'(NOP);
            imm_q     <= '0;
            pc_next_q <= '0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            instr_q   <= instr_i;
            imm_q     <= imm_i;
            pc_next_q <= pc_next_i;
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign imm_o     = imm_q;
    assign pc_next_o = pc_next_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: loads the reset vector from imem words 0/1, then sequences PC and
// assembles one- or two-word instructions into the F/D register for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int IW   = 16,
    parameter int AW   = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_enb,
    input  logic            f_d_enb,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic [IW-1:0]   imem_rdata,
    output logic [AW-1:0]   imem_addr,
    output logic [PC_W-1:0] pc,
    output logic            fd_valid,
    output logic [IW-1:0]   fd_instr,
    output logic [IW-1:0]   fd_imm,
    output logic [PC_W-1:0] fd_pc_next
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   vec_lo_q, vec_lo_d;
    logic [IW-1:0]   hold_q, hold_d;
    logic [PC_W-1:0] pc_inc;

    logic            fd_load, fd_bubble;
    logic [IW-1:0]   fd_instr_in, fd_imm_in;

    assign pc_inc = pc_q + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_LO;
            pc_q     <= '0;
            vec_lo_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vec_lo_q <= vec_lo_d;
            hold_q   <= hold_d;
        end
    end

    // A branch overrides a stall; a stall freezes PC, state and the held first word.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        vec_lo_d = vec_lo_q;
        hold_d   = hold_q;
        unique case (state_q)
            RST_LO: begin
                vec_lo_d = imem_rdata;
                state_d  = RST_HI;
            end
            RST_HI: begin
                pc_d    = PC_W'({imem_rdata, vec_lo_q});
                state_d = RUN;
            end
            RUN, IMM: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = RUN;
                end else if (pc_enb) begin
                    pc_d = pc_inc;
                    if (state_q == IMM) begin
                        state_d = RUN;
                    end else if (is_two_word(imem_rdata)) begin
                        hold_d  = imem_rdata;
                        state_d = IMM;
                    end
                end
            end
            default: state_d = RST_LO;
        endcase
    end

    always_comb begin
        imem_addr   = pc_q[AW-1:0];
        fd_load     = 1'b0;
        fd_bubble   = 1'b0;
        fd_instr_in = (state_q == IMM) ? hold_q : imem_rdata;
        fd_imm_in   = (state_q == IMM) ? imem_rdata : '0;
        unique case (state_q)
            RST_LO: imem_addr = '0;
            RST_HI: imem_addr = AW'(1);
            RUN, IMM: begin
                if (branch_taken) begin
                    fd_bubble = 1'b1;
                end else if (!pc_enb || (state_q == RUN && is_two_word(imem_rdata))) begin
                    fd_bubble = f_d_enb;
                end else begin
                    fd_load = f_d_enb;
                end
            end
            default: imem_addr = '0;
        endcase
    end

    fd_pipe_reg #(.PC_W(PC_W), .IW(IW)) u_fd (
        .clk       (clk),
        .rst       (rst),
        .load_i    (fd_load),
        .bubble_i  (fd_bubble),
        .instr_i   (fd_instr_in),
        .imm_i     (fd_imm_in),
        .pc_next_i (pc_inc),
        .valid_o   (fd_valid),
        .instr_o   (fd_instr),
        .imm_o     (fd_imm),
        .pc_next_o (fd_pc_next)
    );

    assign pc = pc_q;

    // Advancing PC while F/D is held silently drops an instruction.
    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        ((state_q == RUN || state_q == IMM) && !branch_taken) |-> !(pc_enb && !f_d_enb));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run against an instruction-stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_enb;
    logic        f_d_enb;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [15:0] imem_rdata;
    logic [19:0] imem_addr;
    logic [31:0] pc;
    logic        fd_valid;
    logic [15:0] fd_instr;
    logic [15:0] fd_imm;
    logic [31:0] fd_pc_next;

    logic [15:0] mem [0:4095];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[11:0]];

    fetch_unit #(.PC_W(32), .IW(16), .AW(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_enb        (pc_enb),
        .f_d_enb       (f_d_enb),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .fd_valid      (fd_valid),
        .fd_instr      (fd_instr),
        .fd_imm        (fd_imm),
        .fd_pc_next    (fd_pc_next)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_enb = 1'b1; f_d_enb = 1'b1; branch_taken = 1'b0; branch_target = '0;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 16'h0040; mem[1] = 16'h0000;
        rst = 1'b1; pc_enb = 1'b1; f_d_enb = 1'b1; branch_taken = 1'b0; branch_target = '0;
        tick(); tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
        n_cmp++; if (fd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", fd_valid); end
        n_cmp++; if (fd_instr !== 16'h0 || fd_imm !== 16'h0 || fd_pc_next !== 32'h0) begin
            n_err++; $display("FAIL rst_fd got=%h/%h/%h exp=0/0/0", fd_instr, fd_imm, fd_pc_next); end
        n_cmp++; if (imem_addr !== 20'h0) begin n_err++; $display("FAIL rst_addr0 got=%h exp=0", imem_addr); end
        rst = 1'b0;
        tick();
        n_cmp++; if (imem_addr !== 20'h1 || fd_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_hi got addr=%h v=%b exp addr=1 v=0", imem_addr, fd_valid); end
        tick();
        n_cmp++; if (pc !== 32'h40 || fd_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_vec got pc=%h v=%b exp pc=40 v=0", pc, fd_valid); end
    endtask

    task automatic test_straight();
        clear_mem();
        mem[0] = 16'h0040;
        for (int i = 0; i < 5; i++) mem[16'h40 + i] = 16'h1001 + 16'(i);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (fd_valid !== 1'b1 || fd_instr !== 16'h1001 + 16'(i) || fd_pc_next !== 32'h41 + i
                || fd_imm !== 16'h0 || pc !== 32'h41 + i) begin
                n_err++;
                $display("FAIL straight[%0d] got v=%b i=%h m=%h n=%h pc=%h exp v=1 i=%h m=0 n=%h pc=%h",
                         i, fd_valid, fd_instr, fd_imm, fd_pc_next, pc,
                         16'h1001 + 16'(i), 32'h41 + i, 32'h41 + i);
            end
        end
    endtask

    task automatic test_two_word();
        clear_mem();
        mem[0] = 16'h0040; mem[16'h40] = 16'h8123; mem[16'h41] = 16'hBEEF; mem[16'h42] = 16'h1234;
        do_reset();
        tick();
        n_cmp++; if (fd_valid !== 1'b0 || fd_instr !== 16'h0 || pc !== 32'h41) begin
            n_err++; $display("FAIL two_bubble got v=%b i=%h pc=%h exp v=0 i=0 pc=41", fd_valid, fd_instr, pc); end
        tick();
        n_cmp++; if (fd_valid !== 1'b1 || fd_instr !== 16'h8123 || fd_imm !== 16'hBEEF
                     || fd_pc_next !== 32'h42 || pc !== 32'h42) begin
            n_err++; $display("FAIL two_issue got v=%b i=%h m=%h n=%h pc=%h exp 1/8123/beef/42/42",
                              fd_valid, fd_instr, fd_imm, fd_pc_next, pc); end
    endtask

    task automatic test_stall();
        clear_mem();
        mem[0] = 16'h0040;
        for (int i = 0; i < 7; i++) mem[16'h40 + i] = 16'h2000 + 16'(i);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        pc_enb = 1'b0; f_d_enb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pc !== 32'h45 || fd_valid !== 1'b1 || fd_instr !== 16'h2004 || fd_pc_next !== 32'h45) begin
                n_err++; $display("FAIL stall[%0d] got pc=%h v=%b i=%h n=%h exp pc=45 v=1 i=2004 n=45",
                                  i, pc, fd_valid, fd_instr, fd_pc_next);
            end
        end
        pc_enb = 1'b1; f_d_enb = 1'b1;
        tick();
        n_cmp++; if (fd_instr !== 16'h2005 || fd_pc_next !== 32'h46 || pc !== 32'h46 || fd_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_resume got i=%h n=%h pc=%h v=%b exp 2005/46/46/1",
                              fd_instr, fd_pc_next, pc, fd_valid); end
    endtask

    task automatic test_branch_imm();
        clear_mem();
        mem[0] = 16'h0040; mem[16'h40] = 16'h8123; mem[16'h41] = 16'hBEEF; mem[16'h100] = 16'h1111;
        do_reset();
        tick();
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (pc !== 32'h100 || fd_valid !== 1'b0 || fd_instr !== 16'h0) begin
            n_err++; $display("FAIL br_imm got pc=%h v=%b i=%h exp pc=100 v=0 i=0", pc, fd_valid, fd_instr); end
        tick();
        n_cmp++; if (fd_valid !== 1'b1 || fd_instr !== 16'h1111 || fd_imm !== 16'h0 || pc !== 32'h101) begin
            n_err++; $display("FAIL br_after got v=%b i=%h m=%h pc=%h exp 1/1111/0/101",
                              fd_valid, fd_instr, fd_imm, pc); end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        mem[0] = 16'h0040; mem[1] = 16'h0001; mem[16'h40] = 16'h8123;
        do_reset();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h0 || fd_valid !== 1'b0 || imem_addr !== 20'h0) begin
            n_err++; $display("FAIL rmid_rst got pc=%h v=%b a=%h exp 0/0/0", pc, fd_valid, imem_addr); end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (pc !== 32'h0001_0040 || imem_addr !== 20'h10040 || fd_valid !== 1'b0) begin
            n_err++; $display("FAIL rmid_vec got pc=%h a=%h v=%b exp 00010040/10040/0", pc, imem_addr, fd_valid); end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[12'hFFF] = 16'h1234;
        do_reset();
        n_cmp++; if (pc !== 32'hFFFF_FFFF || imem_addr !== 20'hFFFFF) begin
            n_err++; $display("FAIL wrap_vec got pc=%h a=%h exp ffffffff/fffff", pc, imem_addr); end
        tick();
        n_cmp++; if (pc !== 32'h0 || fd_pc_next !== 32'h0 || fd_instr !== 16'h1234 || fd_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap got pc=%h n=%h i=%h v=%b exp 0/0/1234/1", pc, fd_pc_next, fd_instr, fd_valid); end
    endtask

    // Instruction-stream model: where fetch is, what word it still owes, what decode sees.
    int          m_phase;
    logic [31:0] m_pc;
    logic [15:0] m_vlo;
    bit          m_owe_imm;
    logic [15:0] m_first;
    logic        m_fv;
    logic [15:0] m_fi, m_fm;
    logic [31:0] m_fn;

    task automatic model_step();
        logic [15:0] w;
        if (rst) begin
            m_phase = 0; m_pc = 0; m_vlo = 0; m_owe_imm = 0;
            m_fv = 0; m_fi = 0; m_fm = 0; m_fn = 0;
        end else if (m_phase == 0) begin
            m_vlo = mem[0]; m_phase = 1;
        end else if (m_phase == 1) begin
            m_pc = {mem[1], m_vlo}; m_phase = 2;
        end else begin
            w = mem[m_pc[11:0]];
            if (branch_taken) begin
                m_pc = branch_target; m_owe_imm = 0; m_fv = 0; m_fi = 0;
            end else if (!pc_enb) begin
                if (f_d_enb) begin m_fv = 0; m_fi = 0; end
            end else begin
                if (m_owe_imm) begin
                    m_fv = 1; m_fi = m_first; m_fm = w; m_fn = m_pc + 1; m_owe_imm = 0;
                end else if (w[15]) begin
                    m_first = w; m_owe_imm = 1; m_fv = 0; m_fi = 0;
                end else begin
                    m_fv = 1; m_fi = w; m_fm = 0; m_fn = m_pc + 1;
                end
                m_pc = m_pc + 1;
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [19:0] exp_addr;
        clear_mem();
        mem[0] = 16'h0040;
        for (int i = 2; i < 4096; i++) mem[i] = 16'($urandom);
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            branch_taken = (r == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            if (r == 0) begin
                pc_enb = 1'($urandom); f_d_enb = pc_enb | 1'($urandom);
            end else if (r <= 2) begin
                pc_enb = 1'b0; f_d_enb = 1'b0;
            end else if (r == 3) begin
                pc_enb = 1'b0; f_d_enb = 1'b1;
            end else begin
                pc_enb = 1'b1; f_d_enb = 1'b1;
            end
            model_step();
            tick();
            exp_addr = (m_phase == 0) ? 20'h0 : (m_phase == 1) ? 20'h1 : m_pc[19:0];
            n_cmp++; if (pc !== m_pc) begin
                n_err++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, pc, m_pc); end
            n_cmp++; if (imem_addr !== exp_addr) begin
                n_err++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, imem_addr, exp_addr); end
            n_cmp++; if (fd_valid !== m_fv || fd_instr !== m_fi) begin
                n_err++; $display("FAIL rnd_fd cyc=%0d got v=%b i=%h exp v=%b i=%h", c, fd_valid, fd_instr, m_fv, m_fi); end
            if (m_fv) begin
                n_cmp++; if (fd_imm !== m_fm || fd_pc_next !== m_fn) begin
                    n_err++; $display("FAIL rnd_imm cyc=%0d got m=%h n=%h exp m=%h n=%h", c, fd_imm, fd_pc_next, m_fm, m_fn); end
            end
        end
        rst = 1'b0; pc_enb = 1'b1; f_d_enb = 1'b1; branch_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_enb = 1'b1; f_d_enb = 1'b1; branch_taken = 1'b0; branch_target = '0;
        test_reset();
        test_straight();
        test_two_word();
        test_stall();
        test_branch_imm();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
